// File: rtl/opcodes_pkg.sv
// opcodes_pkg: ALU function encodings.
// Shared by decode, the ALU and the ALU arbiter.
package opcodes_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } alu_fn_t;

endpackage

// File: rtl/virgule_pkg.sv
// virgule_pkg: shared core types.
// Holds the datapath word, port index and slot-state types used by the ALU arbiter.
package virgule_pkg;

    typedef logic [31:0] word_t;

    typedef logic port_idx_t;

    localparam int ALU_SHARE_PORTS = 2;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/alu_share_picker.sv
// alu_share_picker: one-hot grant for the two ALU requesters.
// Ports: valid (request vector), last_grant (previous winner), grant (one-hot).
module alu_share_picker
    import virgule_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  logic [ALU_SHARE_PORTS-1:0] valid,
    input  port_idx_t                  last_grant,
    output logic [ALU_SHARE_PORTS-1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                // Conflict: fixed mode favours port 0, otherwise the
                // port that did not win last time.
                if (PRIO_FIXED != 0) begin
                    grant = 2'b01;
                end else begin
                    grant = last_grant ? 2'b01 : 2'b10;
                end
            end
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/arith_logic_unit.sv
// arith_logic_unit: combinational 32-bit integer ALU.
// Ports: fn (function), a/b (operands), r (result). Nop passes b; shifts use b[4:0].
module arith_logic_unit
    import virgule_pkg::*;
    import opcodes_pkg::*;
(
    input  alu_fn_t fn,
    input  word_t   a,
    input  word_t   b,
    output word_t   r
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        r = '0;
        case (fn)
            ALU_NOP:  r = b;
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLL:  r = a << shamt;
            ALU_SRL:  r = a >> shamt;
            ALU_SRA:  r = word_t'($signed(a) >>> shamt);
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            default:  r = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two valid/ready requesters.
// Ports: clk, reset_n (async low), req_valid/ready/fn/a/b per port,
// rsp_valid/ready per port, shared rsp_r. Optional ALU_SHARE_STATS_EN adds
// stat_grant0, stat_grant1, stat_conflict counters.
module alu_share_arbiter
    import virgule_pkg::*;
    import opcodes_pkg::*;
#(
    parameter int PRIO_FIXED = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [ALU_SHARE_PORTS-1:0]    req_valid,
    output logic [ALU_SHARE_PORTS-1:0]    req_ready,
    input  alu_fn_t [ALU_SHARE_PORTS-1:0] req_fn,
    input  word_t [ALU_SHARE_PORTS-1:0]   req_a,
    input  word_t [ALU_SHARE_PORTS-1:0]   req_b,
    output logic [ALU_SHARE_PORTS-1:0]    rsp_valid,
    input  logic [ALU_SHARE_PORTS-1:0]    rsp_ready,
    output word_t                         rsp_r
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [CNT_W-1:0]              stat_grant0,
    output logic [CNT_W-1:0]              stat_grant1,
    output logic [CNT_W-1:0]              stat_conflict
`endif
);

    slot_state_t state_q, state_d;
    port_idx_t   out_port_q, out_port_d;
    port_idx_t   last_grant_q, last_grant_d;
    word_t       out_r_q, out_r_d;

    logic [ALU_SHARE_PORTS-1:0] grant;
    port_idx_t sel;
    logic      drain;
    logic      can_load;
    logic      accept;
    word_t     alu_r;

    alu_share_picker #(
        .PRIO_FIXED(PRIO_FIXED)
    ) u_picker (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign sel = grant[1];

    arith_logic_unit u_alu (
        .fn (req_fn[sel]),
        .a  (req_a[sel]),
        .b  (req_b[sel]),
        .r  (alu_r)
    );

    always_comb begin
        drain    = (state_q == S_FULL) && rsp_ready[out_port_q];
        can_load = (state_q == S_EMPTY) || drain;
        // Gate with reset_n so nothing looks accepted while held in reset.
        req_ready = (reset_n && can_load) ? grant : '0;
        accept    = |req_ready;

        state_d      = state_q;
        out_port_d   = out_port_q;
        last_grant_d = last_grant_q;
        out_r_d      = out_r_q;

        unique case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (drain && !accept) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase

        if (accept) begin
            out_r_d      = alu_r;
            out_port_d   = sel;
            last_grant_d = sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_EMPTY;
            out_port_q   <= 1'b0;
            last_grant_q <= 1'b1;
            out_r_q      <= '0;
        end else begin
            state_q      <= state_d;
            out_port_q   <= out_port_d;
            last_grant_q <= last_grant_d;
            out_r_q      <= out_r_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state_q == S_FULL) rsp_valid[out_port_q] = 1'b1;
    end

    assign rsp_r = out_r_q;

`ifdef ALU_SHARE_STATS_EN
    logic [CNT_W-1:0] grant0_q, grant0_d;
    logic [CNT_W-1:0] grant1_q, grant1_d;
    logic [CNT_W-1:0] conflict_q, conflict_d;

    always_comb begin
        grant0_d   = grant0_q;
        grant1_d   = grant1_q;
        conflict_d = conflict_q;
        if (accept && !sel) grant0_d = grant0_q + CNT_W'(1);
        if (accept && sel)  grant1_d = grant1_q + CNT_W'(1);
        if (accept && (&req_valid)) conflict_d = conflict_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            grant0_q   <= grant0_d;
            grant1_q   <= grant1_d;
            conflict_q <= conflict_d;
        end
    end

    assign stat_grant0   = grant0_q;
    assign stat_grant1   = grant1_q;
    assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter
// against a transaction-level model of the shared result slot.
module tb_alu_share_arbiter;
    import virgule_pkg::*;
    import opcodes_pkg::*;

    localparam int PRIO  = 0;
    localparam int CNT_W = 16;

    logic clk;
    logic reset_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    alu_fn_t [1:0] req_fn;
    word_t [1:0] req_a;
    word_t [1:0] req_b;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    word_t rsp_r;
`ifdef ALU_SHARE_STATS_EN
    logic [CNT_W-1:0] stat_grant0;
    logic [CNT_W-1:0] stat_grant1;
    logic [CNT_W-1:0] stat_conflict;
`endif

    alu_share_arbiter #(
        .PRIO_FIXED (PRIO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fn    (req_fn),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r)
`ifdef ALU_SHARE_STATS_EN
        ,
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the single result slot.
    logic  m_valid;
    int    m_port;
    word_t m_r;
    int    m_last;
    int    last_acc;
    logic [CNT_W-1:0] m_g0, m_g1, m_conf;

    function automatic word_t ref_alu(alu_fn_t fn, word_t a, word_t b);
        longint sa, sb;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (fn)
            ALU_NOP:  return b;
            ALU_ADD:  return word_t'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            ALU_SUB:  return word_t'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return word_t'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
            ALU_SRL:  return word_t'(64'(a) / (64'd1 << sh));
            ALU_SRA:  begin
                // Floor division of the signed value by 2^sh.
                longint q;
                q = sa / (longint'(1) << sh);
                if (sa < 0 && (sa % (longint'(1) << sh)) != 0) q = q - 1;
                return word_t'(q);
            end
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_port   = 0;
        m_r      = '0;
        m_last   = 1;
        last_acc = -1;
        m_g0     = '0;
        m_g1     = '0;
        m_conf   = '0;
    endtask

    // Called just after a falling edge with inputs applied: checks
    // outputs, then advances the model across the next rising edge.
    task automatic step();
        logic [1:0] er;
        logic [1:0] ev;
        logic can;
        int g;
        can = !m_valid || rsp_ready[m_port];
        g = -1;
        if (req_valid == 2'b11) g = (PRIO != 0) ? 0 : 1 - m_last;
        else if (req_valid[0]) g = 0;
        else if (req_valid[1]) g = 1;
        er = '0;
        if (reset_n && can && g >= 0) er[g] = 1'b1;
        ev = '0;
        if (m_valid) ev[m_port] = 1'b1;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        chk("rsp_r", rsp_r, m_r);
`ifdef ALU_SHARE_STATS_EN
        chk("stat_grant0", 32'(stat_grant0), 32'(m_g0));
        chk("stat_grant1", 32'(stat_grant1), 32'(m_g1));
        chk("stat_conflict", 32'(stat_conflict), 32'(m_conf));
`endif
        @(posedge clk);
        last_acc = -1;
        if (!reset_n) begin
            model_reset();
        end else if (er != 2'b00) begin
            m_r      = ref_alu(req_fn[g], req_a[g], req_b[g]);
            m_port   = g;
            m_last   = g;
            m_valid  = 1'b1;
            last_acc = g;
            if (g == 0) m_g0 = m_g0 + 1'b1;
            else        m_g1 = m_g1 + 1'b1;
            if (req_valid == 2'b11) m_conf = m_conf + 1'b1;
        end else if (m_valid && rsp_ready[m_port]) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic v, input alu_fn_t fn,
                           input word_t a, input word_t b);
        req_valid[p] = v;
        req_fn[p]    = fn;
        req_a[p]     = a;
        req_b[p]     = b;
    endtask

    initial begin
        model_reset();
        reset_n   = 1'b0;
        rsp_ready = 2'b00;
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2);

        // Held in reset with requests pending: nothing accepted.
        @(negedge clk);
        step();
        chk("reset_no_acc", 32'(last_acc + 1), 32'd0);

        // Reset released, idle.
        reset_n   = 1'b1;
        req_valid = 2'b00;
        step();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_rsp_r", rsp_r, 32'd0);

        // Single add on port 0.
        set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        step();
        chk("add_acc_port", 32'(last_acc), 32'd0);
        chk("add_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("add_rsp_r", rsp_r, 32'd12);
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        step();

        // Arithmetic shift on port 1.
        set_req(1, 1'b1, ALU_SRA, 32'h8000_0000, 32'd4);
        rsp_ready = 2'b10;
        step();
        chk("sra_rsp_valid", 32'(rsp_valid), 32'b10);
        chk("sra_rsp_r", rsp_r, 32'hF800_0000);
        req_valid = 2'b00;
        step();

        // Continuous contention, both draining every cycle.
        set_req(0, 1'b1, ALU_SUB, 32'd10, 32'd3);
        set_req(1, 1'b1, ALU_SUB, 32'd0, 32'd1);
        rsp_ready = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_grant", 32'(last_acc), 32'(i % 2));
            chk("rr_result", rsp_r, (i % 2 == 0) ? 32'd7 : 32'hFFFF_FFFF);
        end
        req_valid = 2'b00;
        step();

        // Backpressure: held port 0 result blocks port 1.
        set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        rsp_ready = 2'b00;
        step();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, ALU_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_blocked", 32'(last_acc + 1), 32'd0);
            chk("bp_held_r", rsp_r, 32'd3);
        end
        rsp_ready = 2'b01;
        step();
        chk("bp_accept_p1", 32'(last_acc), 32'd1);
        chk("bp_p1_r", rsp_r, 32'hFF00_FF00);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();

        // Reset mid-operation while the slot holds a result.
        chk("pre_rst_full", 32'(rsp_valid), 32'b10);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_r", rsp_r, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 2'b11;
        step();
        step();
        chk("no_stale_rsp", 32'(rsp_valid), 32'd0);

        // Randomized traffic; pending requests stay stable until taken.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(req_valid[p] && last_acc != p)) begin
                    set_req(p, $urandom_range(0, 3) != 0,
                            alu_fn_t'($urandom_range(0, 10)),
                            word_t'($urandom),
                            ($urandom_range(0, 1) != 0) ? word_t'($urandom_range(0, 40))
                                                        : word_t'($urandom));
                end
            end
            rsp_ready[0] = $urandom_range(0, 9) < 7;
            rsp_ready[1] = $urandom_range(0, 9) < 7;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares a single integer ALU datapath between two requesters, e.g. the execute stage and a branch/address-compute unit, behind valid/ready handshakes. Arbitration is round-robin or fixed-priority. The block owns one registered result slot and routes each result back to the requester that issued it. It sits between the decode/issue logic and the shared `arith_logic_unit` instance.

## Interface
- `PRIO_FIXED`, default 0: 0 = round-robin; 1 = port 0 always wins.
- `CNT_W`, default 16: statistics counter width; used only under the statistics macro.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 2: per-port request valid.
- `req_ready` out 2: per-port request accepted this cycle.
- `req_fn` in 2×`alu_fn_t`: per-port ALU function.
- `req_a`, `req_b` in 2×`word_t`: per-port operands.
- `rsp_valid` out 2: result available for that port.
- `rsp_ready` in 2: requester consumes the result.
- `rsp_r` out `word_t`: shared result bus, meaningful for the port whose `rsp_valid` is high.
- Statistics only: `stat_grant0` out `CNT_W`, `stat_grant1` out `CNT_W`, `stat_conflict` out `CNT_W`.

## Operation
- **Result slot contents:** `out_valid`, `out_port`, `out_r`.
- **State machine:** two states.
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- **Slot can load:** `can_load` = EMPTY, or FULL and `rsp_ready[out_port]` = 1 (drain and refill in the same cycle).
- **Grant selection, one port only valid:** that port is granted.
- **Grant selection, both ports valid:**
  - Round-robin: grant the port not equal to `last_grant`.
  - `PRIO_FIXED`=1: grant port 0.
- **Ready:** `req_ready[i]` = `grant[i]` & `can_load`. This is combinational from `req_valid`, `rsp_ready` and state. A requester must not make `req_valid` depend on `req_ready`.
- **Acceptance of port i:**
  - The ALU evaluates `req_fn[i]`, `req_a[i]`, `req_b[i]` in the same cycle.
  - On the next edge: `out_r` ← ALU result, `out_port` ← i, `out_valid` ← 1, `last_grant` ← i.
- **Drain without new acceptance:** FULL → EMPTY.
- **Response routing:** `rsp_valid[i]` = `out_valid` & (`out_port` == i). `rsp_r` = `out_r`.
- **Requester obligation:** `req_*` stays stable while `req_valid` is high and the request is not yet accepted.
- **ALU semantics:** unchanged. The nop function passes `b`. Shifts use `b[4:0]`. Comparisons return 0 or 1. All arithmetic wraps modulo 2^32.
- **Boundary conditions:**
  - A held result blocks both ports; no port is granted while the slot is FULL and not draining.
  - A non-granted valid request waits; its `req_ready` = 0.
  - `rsp_ready` on a port with `rsp_valid` = 0 is ignored.
  - Reset mid-operation discards any held result; no response is ever produced for it.

## Timing
- **Reset values:**
  - `out_valid` = 0, so all `rsp_valid` = 0.
  - `out_r` = 0, `out_port` = 0.
  - `last_grant` = 1, so port 0 wins the first conflict.
  - `req_ready` = 0 while in reset.
  - Statistics counters = 0.
- **Latency:** accept in cycle N, `rsp_valid` high in cycle N+1.
- **Throughput:** one operation per cycle while the owning requester holds `rsp_ready` high.
- **Round-robin contention:** under continuous conflict with immediate drains, grants alternate 0,1,0,1…
- **Result stability:** `rsp_r` holds until consumed.

## Configuration
- `ALU_SHARE_STATS_EN` defined:
  - The three `stat_*` ports exist.
  - `stat_grantN` increments on each acceptance by port N.
  - `stat_conflict` increments in each cycle where both `req_valid` are high and one request is accepted.
  - All counters wrap at 2^`CNT_W`.
- Not defined: the ports and counters are absent. Functional behaviour is identical.

## Structure
- **Package `virgule_pkg`:** already holds `word_t`. Add:
  - `port_idx_t` (1 bit).
  - `ALU_SHARE_PORTS` = 2.
- **Package `opcodes_pkg`:** keep `alu_fn_t` there.
- **Sub-module `alu_share_picker`:** combinational grant logic (valid vector, `last_grant`, `PRIO_FIXED` → one-hot grant).
- **Datapath:** the existing `arith_logic_unit` is instantiated once, fed through a 2:1 operand mux selected by the grant.

## Test plan
- **Reset and idle:** release `reset_n`, no requests → all `req_ready` and `rsp_valid` are 0, `rsp_r` = 0.
- **Single add:** port 0 add, a=5, b=7 → `req_ready[0]` in cycle N; `rsp_valid[0]` and `rsp_r`=12 in cycle N+1; `rsp_valid[1]` = 0.
- **Arithmetic shift:** port 1 sra, a=0x80000000, b=4 → `rsp_r`=0xF8000000 on port 1.
- **Contention and back-to-back:** both ports sub continuously (port 0: 10−3; port 1: 0−1), `rsp_ready` tied high → grants 0,1,0,…, results 7, 0xFFFFFFFF alternating, one per cycle, no bubbles.
- **Backpressure:** port 0 result held with `rsp_ready[0]`=0 for 3 cycles while port 1 is valid → `req_ready[1]`=0 throughout. Port 1 is accepted in the cycle `rsp_ready[0]` rises.
- **Reset mid-operation:** assert `reset_n`=0 while FULL → `rsp_valid` falls immediately (asynchronous). After release, no stale response appears.
